regfile_access_arbiter: RTL and testbench
=========================================

Name: regfile_access_arbiter

Overview:
Two-requester arbiter and sequencer for the 4 x 8-bit register file ($s0, $s1, $sp, $ra).
- Requester 0 is the core control path; requester 1 is the loader/debug port.
- Grants one register-file access at a time with round-robin fairness.
- Drives the register-file address, write-data and write-enable lines, and returns read data with a done pulse.

Parameters:
DATA_W, 8, register data width
ADDR_W, 2, register address width (4 registers)
RA_ADDR, 2'b11, address of $ra; write-protected from requester 1 when PROTECT_RA=1
PROTECT_RA, 1, 1 = requester 1 writes to RA_ADDR are dropped

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 access request; hold with command stable until gnt0
we0  in  1  requester 0: 1 = write, 0 = read
addr0  in  ADDR_W  requester 0 register address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  one-cycle pulse: requester 0 command accepted
done0  out  1  one-cycle pulse: requester 0 access complete, rdata0 valid
rdata0  out  DATA_W  requester 0 result, held until its next done0
req1, we1, addr1, wdata1, gnt1, done1, rdata1: same as above, for requester 1
rf_addr  out  ADDR_W  register-file address
rf_wdata  out  DATA_W  register-file write data
rf_we  out  1  register-file write enable, one-cycle pulse
rf_rdata  in  DATA_W  register-file read data; combinational from rf_addr
err1  out  1  one-cycle pulse with done1 when a protected write was dropped

Behaviour:
Reset:
- Applies to all outputs: gnt*/done*/rf_we/err1 = 0; rdata0/rdata1/rf_addr/rf_wdata = 0.
- State = IDLE; round-robin pointer last = 1, so requester 0 wins the first tie.

FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Neither req: stay.
  - One req: select it.
  - Both req: select the requester not equal to last.
  - On selection: latch winner id, we, addr and wdata into internal registers; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - gnt_winner = 1.
  - rf_addr = latched addr; rf_wdata = latched wdata.
  - rf_we = latched we, except 0 when winner = 1, PROTECT_RA = 1 and addr = RA_ADDR.
  - Read: rf_rdata is captured into rdata_winner at the end of the cycle.
  - Write: rdata_winner = latched wdata (echo).
  - Next state RESP.
- RESP (exactly 1 cycle):
  - done_winner = 1.
  - err1 = 1 if the write was dropped.
  - last = winner.
  - Next state IDLE.

Timing and handshake:
- Latency: req sampled high in IDLE at cycle N, gnt at N+1, done at N+2. Minimum 3 cycles per access.
- The requester may drop req the cycle after gnt. If req is still high in the next IDLE cycle, it is treated as a new request.
- rf_addr/rf_wdata hold their ACCESS values until the next ACCESS (no glitch to 0). rf_we is high only in ACCESS.
- A req asserted during ACCESS/RESP waits. Command inputs are ignored outside IDLE.
- Fairness: under continuous requests from both, grants strictly alternate 0,1,0,1.

Boundary and simultaneous events:
- Reset during ACCESS: rf_we is 0 from the next edge; no done is issued; the latched command is discarded.
- Reset during RESP: done is suppressed.
- Write then read of the same address by different requesters returns the new value (the register file commits at the ACCESS edge; the read occurs ≥2 cycles later).
- rdata of the non-winning requester never changes.
- Only one of gnt0/gnt1 is high in any cycle; the same holds for done0/done1.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, rf_we never asserted.
- req0 write addr=1 data=8'h5A at cycle 0 -> gnt0 @1 with rf_we=1, rf_addr=1, rf_wdata=5A; done0 @2 with rdata0=5A.
- req0 and req1 both read from cycle 0 held high; reg2 preloaded 8'h3C -> grant order 0,1,0,1; each done returns 3C; gnt cycles 1,4,7,10.
- req1 write addr=3 data=8'hFF with PROTECT_RA=1 -> rf_we stays 0; done1 and err1 pulse together; a later req0 read of addr 3 returns the prior value 00.
- req1 write addr=0 data=8'h11 followed by req0 read addr=0 -> rdata0=11 at its done0.
- Assert reset in the ACCESS cycle of a write -> no done pulse, state IDLE, rf_we=0; the next request completes normally with 3-cycle latency.

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// Two-requester round-robin arbiter that sequences one register-file access
// at a time: IDLE selects and latches a command, ACCESS drives the file, RESP reports.
module regfile_access_arbiter #(
  parameter int unsigned           DATA_W     = 8,
  parameter int unsigned           ADDR_W     = 2,
  parameter logic [ADDR_W-1:0]     RA_ADDR    = 2'b11,
  parameter bit                    PROTECT_RA = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              err1
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic                last;
  logic                sel_vld, sel;
  logic                win_p0, we_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic                blocked;

  // A write from the loader port to the return-address register is dropped.
  function automatic logic ra_blocked(input logic win, input logic we,
                                      input logic [ADDR_W-1:0] addr);
    return PROTECT_RA && win && we && (addr == RA_ADDR);
  endfunction

  assign blocked = ra_blocked(win_p0, we_p0, addr_p0);

  // On a tie the requester that was not served last wins.
  always_comb begin
    sel_vld = req0 | req1;
    sel     = 1'b0;
    if (req0 && req1) sel = ~last;
    else if (req1)    sel = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == RESP) last <= win_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sel_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: command latched at selection; also drives rf_addr/rf_wdata
  // so they hold steady between accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_p0   <= 1'b0;
      we_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
    end else if (state == IDLE && sel_vld) begin
      win_p0   <= sel;
      we_p0    <= sel ? we1    : we0;
      addr_p0  <= sel ? addr1  : addr0;
      wdata_p0 <= sel ? wdata1 : wdata0;
    end
  end

  // Result capture at the end of ACCESS; writes echo their data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ACCESS) begin
      if (win_p0) rdata1 <= we_p0 ? wdata_p0 : rf_rdata;
      else        rdata0 <= we_p0 ? wdata_p0 : rf_rdata;
    end
  end

  assign rf_addr  = addr_p0;
  assign rf_wdata = wdata_p0;

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    rf_we = 1'b0;
    err1  = 1'b0;
    unique case (state)
      ACCESS: begin
        gnt0  = ~win_p0;
        gnt1  = win_p0;
        rf_we = we_p0 & ~blocked;
      end
      RESP: begin
        done0 = ~win_p0;
        done1 = win_p0;
        err1  = blocked;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Scoreboard bench for regfile_access_arbiter with a behavioural 4 x 8 register file.
module tb_regfile_access_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [1:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, done0, gnt1, done1, rf_we, err1;
  logic [7:0] rdata0, rdata1, rf_wdata, rf_rdata;
  logic [1:0] rf_addr;
  logic [7:0] rf_mem [0:3];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         gq[$];

  regfile_access_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .rf_rdata(rf_rdata), .err1(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= 8'h00;
    end else if (rf_we) begin
      rf_mem[rf_addr] <= rf_wdata;
    end
  end

  assign rf_rdata = rf_mem[rf_addr];

  task automatic start_req(input int id, input logic we, input logic [1:0] a,
                           input logic [7:0] d, output int start);
    @(posedge clk); #1;
    start = cyc;
    if (id == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else         begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic wait_access(input int id, input int start, output bit ok,
                             output int gcyc, output int dcyc, output logic [7:0] rd,
                             output logic er, output logic wes, output logic [1:0] as,
                             output logic [7:0] ws);
    ok = 1'b0; gcyc = -1; dcyc = -1; rd = '0; er = 1'b0; wes = 1'b0; as = '0; ws = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((id == 0 ? gnt0 : gnt1) === 1'b1) begin
        gcyc = cyc - start; wes = rf_we; as = rf_addr; ws = rf_wdata;
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
      end
      if ((id == 0 ? done0 : done1) === 1'b1) begin
        dcyc = cyc - start; rd = (id == 0) ? rdata0 : rdata1; er = err1; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, done0, done1, rdata0, rdata1, rf_addr, rf_wdata, rf_we, err1} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got gnt=%b%b done=%b%b rd0=%h rd1=%h a=%h wd=%h we=%b err=%b want all 0",
                 i, gnt0, gnt1, done0, done1, rdata0, rdata1, rf_addr, rf_wdata, rf_we, err1);
      end
    end
  endtask

  task automatic test_write();
    int st, g, d; bit ok; logic [7:0] rd, ws, exp; logic er, wes; logic [1:0] as;
    start_req(0, 1'b1, 2'd1, 8'h5A, st);
    q0.push_back(8'h5A);
    wait_access(0, st, ok, g, d, rd, er, wes, as, ws);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_timeout got no done0 want done0"); end
    checks++;
    if (g !== 1) begin errors++; $display("FAIL wr_gnt_cycle got %0d want 1", g); end
    checks++;
    if ({wes, as, ws} !== {1'b1, 2'd1, 8'h5A}) begin
      errors++; $display("FAIL wr_rf_drive got we=%b a=%0d wd=%h want we=1 a=1 wd=5a", wes, as, ws);
    end
    checks++;
    if (d !== 2) begin errors++; $display("FAIL wr_done_cycle got %0d want 2", d); end
    exp = (q0.size() != 0) ? q0.pop_front() : 8'hxx;
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL wr_rdata0 got %h want %h", rd, exp); end
  endtask

  task automatic test_protect();
    int st, g, d; bit ok; logic [7:0] rd, ws, exp; logic er, wes; logic [1:0] as;
    start_req(1, 1'b1, 2'd3, 8'hFF, st);
    q1.push_back(8'hFF);
    wait_access(1, st, ok, g, d, rd, er, wes, as, ws);
    checks++;
    if (!ok || g !== 1 || d !== 2) begin
      errors++; $display("FAIL prot_timing got ok=%0d gnt=%0d done=%0d want 1 1 2", ok, g, d);
    end
    checks++;
    if (wes !== 1'b0) begin errors++; $display("FAIL prot_rf_we got %b want 0", wes); end
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL prot_err1 got %b want 1", er); end
    exp = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL prot_rdata1 got %h want %h", rd, exp); end
    start_req(0, 1'b0, 2'd3, 8'h00, st);
    q0.push_back(8'h00);
    wait_access(0, st, ok, g, d, rd, er, wes, as, ws);
    exp = (q0.size() != 0) ? q0.pop_front() : 8'hxx;
    checks++;
    if (!ok || rd !== exp) begin
      errors++; $display("FAIL prot_readback got ok=%0d rd=%h want ok=1 rd=%h", ok, rd, exp);
    end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL prot_err_read got %b want 0", er); end
  endtask

  task automatic test_wr_rd();
    int st, g, d; bit ok; logic [7:0] rd, ws, exp; logic er, wes; logic [1:0] as;
    start_req(1, 1'b1, 2'd0, 8'h11, st);
    q1.push_back(8'h11);
    wait_access(1, st, ok, g, d, rd, er, wes, as, ws);
    exp = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
    checks++;
    if (!ok || rd !== exp || wes !== 1'b1 || er !== 1'b0) begin
      errors++; $display("FAIL wrrd_write got ok=%0d rd=%h we=%b err=%b want 1 %h 1 0", ok, rd, wes, er, exp);
    end
    start_req(0, 1'b0, 2'd0, 8'h00, st);
    q0.push_back(8'h11);
    wait_access(0, st, ok, g, d, rd, er, wes, as, ws);
    exp = (q0.size() != 0) ? q0.pop_front() : 8'hxx;
    checks++;
    if (!ok || rd !== exp) begin
      errors++; $display("FAIL wrrd_read got ok=%0d rd=%h want ok=1 rd=%h", ok, rd, exp);
    end
    checks++;
    if (rdata1 !== 8'h11) begin errors++; $display("FAIL wrrd_rdata1_hold got %h want 11", rdata1); end
  endtask

  task automatic test_fairness();
    int st, g, d, ng, nd, id, exp_id; bit ok; logic [7:0] rd, ws, exp; logic er, wes; logic [1:0] as;
    start_req(1, 1'b1, 2'd2, 8'h3C, st);
    q1.push_back(8'h3C);
    wait_access(1, st, ok, g, d, rd, er, wes, as, ws);
    exp = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
    checks++;
    if (!ok || rd !== exp) begin
      errors++; $display("FAIL fair_preload got ok=%0d rd=%h want ok=1 rd=%h", ok, rd, exp);
    end
    @(posedge clk); #1;
    st = cyc;
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd2;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd2;
    gq = '{0, 1, 0, 1};
    q0.push_back(8'h3C); q0.push_back(8'h3C);
    q1.push_back(8'h3C); q1.push_back(8'h3C);
    ng = 0; nd = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ((gnt0 & gnt1) || (done0 & done1)) begin
        errors++; $display("FAIL fair_exclusive got gnt=%b%b done=%b%b want at most one each", gnt0, gnt1, done0, done1);
      end
      if (gnt0 || gnt1) begin
        id = gnt1 ? 1 : 0;
        exp_id = (gq.size() != 0) ? gq.pop_front() : -1;
        checks++;
        if (id !== exp_id) begin errors++; $display("FAIL fair_order grant %0d got %0d want %0d", ng, id, exp_id); end
        checks++;
        if (cyc - st !== 1 + 3 * ng) begin
          errors++; $display("FAIL fair_gnt_cycle grant %0d got %0d want %0d", ng, cyc - st, 1 + 3 * ng);
        end
        ng++;
        if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (done0 || done1) begin
        rd = done1 ? rdata1 : rdata0;
        if (done1) exp = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
        else       exp = (q0.size() != 0) ? q0.pop_front() : 8'hxx;
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL fair_rdata done %0d got %h want %h", nd, rd, exp); end
        nd++;
        if (nd == 4) break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (nd != 4) begin errors++; $display("FAIL fair_timeout got %0d dones want 4", nd); end
  endtask

  task automatic test_reset_access();
    int st, g, d; bit ok, got; logic [7:0] rd, ws, exp; logic er, wes; logic [1:0] as;
    start_req(0, 1'b1, 2'd2, 8'h77, st);
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (gnt0 === 1'b1) begin got = 1'b1; reset = 1'b1; req0 = 1'b0; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rst_acc_gnt got no gnt0 want gnt0"); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({gnt0, gnt1, done0, done1, rf_we, err1} !== 6'b0) begin
        errors++; $display("FAIL rst_acc_quiet cycle %0d got gnt=%b%b done=%b%b we=%b err=%b want 0",
                           i, gnt0, gnt1, done0, done1, rf_we, err1);
      end
      @(negedge clk);
    end
    checks++;
    if (rdata0 !== 8'h00) begin errors++; $display("FAIL rst_acc_rdata0 got %h want 00", rdata0); end
    start_req(1, 1'b1, 2'd1, 8'h42, st);
    q1.push_back(8'h42);
    wait_access(1, st, ok, g, d, rd, er, wes, as, ws);
    exp = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
    checks++;
    if (!ok || g !== 1 || d !== 2) begin
      errors++; $display("FAIL rst_acc_latency got ok=%0d gnt=%0d done=%0d want 1 1 2", ok, g, d);
    end
    checks++;
    if (rd !== exp || wes !== 1'b1) begin
      errors++; $display("FAIL rst_acc_next got rd=%h we=%b want rd=%h we=1", rd, wes, exp);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_protect();
    test_wr_rd();
    test_fairness();
    test_reset_access();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
